// File: rtl/fir_pkg.sv
// fir_pkg: FSM state type and accumulator-width helper shared by the FIR decimator.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int acc_w(int dw, int cw, int taps);
    return dw + cw + $clog2(taps);
  endfunction
endpackage

// File: rtl/fir_decim_mc_if.sv
// fir_decim_mc_if: input/output streams and coefficient write port of the FIR decimator.
interface fir_decim_mc_if #(
  parameter int TAP_COUNT  = 121,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int P_SAMPLES  = 8
);
  logic s_tvalid, s_tready, m_tvalid, m_tready, coef_wr_en;
  logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] s_tdata;
  logic [CHANNELS*OUT_WIDTH-1:0] m_tdata;
  logic [$clog2(TAP_COUNT)-1:0] coef_wr_addr;
  logic [COEF_WIDTH-1:0] coef_wr_data;
  modport slave (
    input  s_tvalid, s_tdata, m_tready, coef_wr_en, coef_wr_addr, coef_wr_data,
    output s_tready, m_tvalid, m_tdata
  );
  modport master (
    output s_tvalid, s_tdata, m_tready, coef_wr_en, coef_wr_addr, coef_wr_data,
    input  s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: per-channel accumulator, output shift and reduction to OUT_WIDTH.
// FIR_SAT_EN selects saturation; otherwise the output wraps.
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int TAP_COUNT  = 121,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         ld,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [COEF_WIDTH-1:0] h,
  output logic [OUT_WIDTH-1:0]         y
);
  localparam int AW = acc_w(DATA_WIDTH, COEF_WIDTH, TAP_COUNT);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] p;
  logic [OUT_WIDTH-1:0] r;
  assign p = PW'(x) * PW'(h);
`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] HI = {{(AW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] LO = {{(AW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic signed [AW-1:0] sh;
  assign sh = acc >>> SHIFT;
  assign r  = sh > HI ? HI[OUT_WIDTH-1:0] : sh < LO ? LO[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
`else
  assign r = OUT_WIDTH'(acc >>> SHIFT);
`endif
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clr) acc <= '0;
      else if (en) acc <= acc + AW'(p);
      if (ld) y <= r;
    end
endmodule

// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multi-channel FIR decimating by P_SAMPLES, one MAC per channel per cycle.
// Define FIR_SAT_EN for saturating channel outputs (default wraps).
module fir_decim_mc
  import fir_pkg::*;
#(
  parameter int TAP_COUNT  = 121,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int P_SAMPLES  = 8,
  parameter int SHIFT      = 15
) (
  input logic           clk,
  input logic           rst,
  fir_decim_mc_if.slave bus
);
  localparam int KW = $clog2(TAP_COUNT);
  state_t state;
  logic [KW-1:0] k;
  logic vld, acc_ok, last;
  logic signed [DATA_WIDTH-1:0] tap [CHANNELS][TAP_COUNT];
  logic signed [COEF_WIDTH-1:0] coef [TAP_COUNT];
  logic [CHANNELS*OUT_WIDTH-1:0] md;
  assign bus.s_tready = state == IDLE && !rst;
  assign bus.m_tvalid = vld;
  assign bus.m_tdata  = md;
  assign acc_ok = bus.s_tvalid && bus.s_tready;
  assign last   = k == KW'(TAP_COUNT - 1);
  // coefficients survive reset; writes outside IDLE are dropped
  always_ff @(posedge clk)
    if (state == IDLE && bus.coef_wr_en && int'(bus.coef_wr_addr) < TAP_COUNT)
      coef[bus.coef_wr_addr] <= bus.coef_wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state == IDLE ? (acc_ok ? MAC : IDLE)
             : state == MAC  ? (last ? OUT : MAC)
             : (vld && bus.m_tready ? IDLE : OUT);
      k     <= state == MAC ? k + 1'b1 : '0;
      vld   <= state == OUT && !(vld && bus.m_tready);
    end
  always_ff @(posedge clk)
    if (rst) tap <= '{default: '0};
    else if (acc_ok)
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = P_SAMPLES; i < TAP_COUNT; i++) tap[c][i] <= tap[c][i-P_SAMPLES];
        for (int j = 0; j < P_SAMPLES; j++)
          tap[c][j] <= bus.s_tdata[(c*P_SAMPLES+P_SAMPLES-1-j)*DATA_WIDTH +: DATA_WIDTH];
      end
  // the output register loads on the first OUT cycle, once the last MAC has landed
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    fir_mac_lane #(
      .TAP_COUNT(TAP_COUNT), .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
      .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(acc_ok),
      .en(state == MAC),
      .ld(state == OUT && !vld),
      .x(tap[c][k]),
      .h(coef[k]),
      .y(md[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end
endmodule

// File: tb/tb_fir_decim_mc.sv
// tb_fir_decim_mc: table-driven impulse plus hand sequences for latency, stall, reset and coefficient timing.
module tb_fir_decim_mc;
  localparam int TAPS = 121, DW = 16, CW = 16, OW = 16, CH = 2, P = 8;
  localparam int AD = $clog2(TAPS);
  typedef struct {
    logic [CH*P*DW-1:0] d;
    logic [CH*OW-1:0]   e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fir_decim_mc_if #(.TAP_COUNT(TAPS), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW),
                    .CHANNELS(CH), .P_SAMPLES(P)) bus ();
  fir_decim_mc #(.TAP_COUNT(TAPS), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW),
                 .CHANNELS(CH), .P_SAMPLES(P), .SHIFT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  vec_t vecs [17];
  logic [CH*OW-1:0] q [$];
  int ncmp = 0, nfail = 0, nb = 0;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endfunction
  function automatic void timeout(string n);
    ncmp++;
    nfail++;
    $display("FAIL %s: bound expired waiting on DUT", n);
  endfunction
  function automatic logic [15:0] dc(int m);
    longint s = (longint'(m) * 32767 * 32767) >>> 15;
`ifdef FIR_SAT_EN
    return s > 32767 ? 16'h7fff : 16'(s);
`else
    return 16'(s);
`endif
  endfunction
  always @(negedge clk)
    if (bus.m_tvalid === 1'b1 && bus.m_tready) begin
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_beat: got %0h, expected no output", bus.m_tdata);
      end else chk($sformatf("beat%0d", nb), 64'(bus.m_tdata), 64'(q.pop_front()));
      nb++;
    end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic wcoef(int a, logic [CW-1:0] v);
    bus.coef_wr_en = 1'b1;
    bus.coef_wr_addr = AD'(a);
    bus.coef_wr_data = v;
    tick();
    bus.coef_wr_en = 1'b0;
  endtask
  task automatic send(logic [CH*P*DW-1:0] d, logic [CH*OW-1:0] e, bit push);
    int n = 0;
    bus.s_tdata = d;
    bus.s_tvalid = 1'b1;
    while (!bus.s_tready && n < 1000) begin
      tick();
      n++;
    end
    if (n == 1000) timeout("send");
    if (push) q.push_back(e);
    tick();
    bus.s_tvalid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      timeout("drain");
      q.delete();
    end
    tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic [CH*P*DW-1:0] imp, ones, full;
    logic [CH*OW-1:0] v;
    int n, bad, rdy;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    bus.m_tready = 1'b1;
    bus.coef_wr_en = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    imp = '0;
    imp[7*DW +: DW] = 16'h4000;
    ones = {CH*P{16'h4000}};
    full = {CH*P{16'h7fff}};
    for (int i = 0; i < 17; i++) begin
      vecs[i].d = i == 0 ? imp : '0;
      vecs[i].e = i <= 15 ? 32'(8*i + 1) : '0;
    end
    tick(3);
    chk("rst_s_tready", 64'(bus.s_tready), 0);
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 0);
    chk("rst_m_tdata", 64'(bus.m_tdata), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_tready", 64'(bus.s_tready), 1);
    // impulse: 0x4000 * 2(k+1) >>> 15 = k+1
    for (int k = 0; k < TAPS; k++) wcoef(k, 16'(2*(k+1)));
    for (int i = 0; i < 17; i++) send(vecs[i].d, vecs[i].e, 1'b1);
    drain();
    send(imp, 32'd1, 1'b1);
    n = 0;
    while (!bus.m_tvalid && n < 300) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 122);
    drain();
    pulse_rst();
    send(imp, 32'd1, 1'b1);
    tick(10);
    wcoef(0, 16'd10);
    drain();
    wcoef(0, 16'd10);
    pulse_rst();
    send(imp, 32'd5, 1'b1);
    drain();
    pulse_rst();
    bus.coef_wr_en = 1'b1;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = 16'd4;
    send(imp, 32'd2, 1'b1);
    bus.coef_wr_en = 1'b0;
    drain();
    // abort mid-MAC; coef[8] exposes any tap that survived the reset
    for (int k = 0; k < TAPS; k++) wcoef(k, (k == 0 || k == 8) ? 16'd2 : 16'd0);
    send(ones, '0, 1'b0);
    tick(40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      tick();
      if (bus.m_tvalid) bad++;
    end
    chk("abort_no_valid", 64'(bad), 0);
    send(ones, {16'd1, 16'd1}, 1'b1);
    drain();
    for (int k = 0; k < TAPS; k++) wcoef(k, 16'h7fff);
    pulse_rst();
    for (int i = 0; i < 15; i++) send(full, {2{dc(8*(i+1))}}, 1'b1);
    drain();
    bus.m_tready = 1'b0;
    send(full, {2{dc(121)}}, 1'b1);
    n = 0;
    while (!bus.m_tvalid && n < 300) begin
      tick();
      n++;
    end
    if (n == 300) timeout("stall_valid_wait");
    v = bus.m_tdata;
    bad = 0;
    rdy = 0;
    repeat (50) begin
      tick();
      if (bus.m_tdata !== v) bad++;
      if (bus.s_tready) rdy++;
    end
    chk("stall_data_stable", 64'(bad), 0);
    chk("stall_s_tready", 64'(rdy), 0);
    chk("stall_m_tvalid", 64'(bus.m_tvalid), 1);
    chk("stall_queued", 64'(q.size()), 1);
    bus.m_tready = 1'b1;
    bus.s_tdata = full;
    bus.s_tvalid = 1'b1;
    q.push_back({2{dc(121)}});
    tick();
    chk("hs_then_ready", 64'(bus.s_tready), 1);
    tick();
    chk("next_accepted", 64'(bus.s_tready), 0);
    bus.s_tvalid = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fir_decim_mc.md
FIR_DECIM_MC -- requirements
Module: fir_decim_mc

Interface
REQ-001 Parameter TAP_COUNT, 121, number of filter taps per channel (>= P_SAMPLES).
REQ-002 Parameter DATA_WIDTH, 16, signed input sample width.
REQ-003 Parameter COEF_WIDTH, 16, signed coefficient width.
REQ-004 Parameter OUT_WIDTH, 16, signed output width per channel.
REQ-005 Parameter CHANNELS, 2, independent channels sharing one coefficient set.
REQ-006 Parameter P_SAMPLES, 8, parallel samples per channel per input beat; this is also the decimation ratio.
REQ-007 Parameter SHIFT, 15, arithmetic right shift applied to the accumulator before output.
REQ-008 clk  input  1  sole clock; all state changes on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 s_tvalid  input  1  input beat valid.
REQ-011 s_tready  output  1  block can accept an input beat.
REQ-012 s_tdata  input  CHANNELS*P_SAMPLES*DATA_WIDTH  channel c, lane j at bits [(c*P_SAMPLES+j)*DATA_WIDTH +: DATA_WIDTH]; lane P_SAMPLES-1 is the newest sample.
REQ-013 m_tvalid  output  1  output beat valid.
REQ-014 m_tready  input  1  downstream accepts the output beat.
REQ-015 m_tdata  output  CHANNELS*OUT_WIDTH  channel c result at bits [c*OUT_WIDTH +: OUT_WIDTH].
REQ-016 coef_wr_en  input  1  coefficient write strobe.
REQ-017 coef_wr_addr  input  $clog2(TAP_COUNT)  coefficient index; tap 0 multiplies the newest sample.
REQ-018 coef_wr_data  input  COEF_WIDTH  signed coefficient value.

Function
REQ-019 The FSM SHALL have states IDLE, MAC and OUT; transitions are IDLE->MAC on s_tvalid&&s_tready, MAC->OUT after the last tap, and OUT->IDLE on m_tvalid&&m_tready.
REQ-020 s_tready SHALL be 1 only in IDLE; m_tvalid SHALL be 1 only in OUT.
REQ-021 On an accepted beat, each channel delay line SHALL shift by P_SAMPLES (tap[i]<=tap[i-P_SAMPLES] for i>=P_SAMPLES) and load tap[j]<=lane[P_SAMPLES-1-j].
REQ-022 MAC SHALL last exactly TAP_COUNT cycles, one multiply-accumulate per channel per cycle over tap index k=0..TAP_COUNT-1; the accumulators clear at acceptance.
REQ-023 Accumulator width SHALL be DATA_WIDTH+COEF_WIDTH+$clog2(TAP_COUNT) signed, so no internal overflow occurs.
REQ-024 m_tvalid SHALL rise TAP_COUNT+1 cycles after the accepting edge, giving a throughput of one output beat per input beat (decimation by P_SAMPLES).
REQ-025 m_tdata SHALL hold stable while m_tvalid=1 and m_tready=0, for unlimited stall.
REQ-026 A coefficient write SHALL take effect only in IDLE and SHALL be silently ignored in MAC or OUT; a write coincident with acceptance takes effect before the MAC starts.
REQ-027 coef_wr_addr >= TAP_COUNT SHALL be ignored.
REQ-028 The output SHALL be the accumulator shifted arithmetically right by SHIFT, with truncation toward negative infinity, then reduced to OUT_WIDTH per Configuration.

Reset
REQ-029 When rst=1 at a clock edge: state=IDLE, all taps=0, accumulators=0, m_tvalid=0, m_tdata=0, s_tready=0 during the reset cycle and 1 on the first cycle after.
REQ-030 Reset asserted in MAC or OUT SHALL abort the computation without emitting output; coefficients SHALL NOT be reset.

Configuration
REQ-031 With FIR_SAT_EN defined, each channel output SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; without it, the output SHALL be the low OUT_WIDTH bits (two's-complement wrap).

Structure
REQ-032 Package fir_pkg SHALL hold the state enum typedef and an acc-width helper function; parameters stay on the module.
REQ-033 Sub-module fir_mac_lane (one per channel: accumulator, shift, saturate/wrap) SHALL be instantiated CHANNELS times.

Verification
REQ-034 Impulse: SHIFT=0, OUT_WIDTH=32, coef[k]=k+1, beat 0 ch0 lane 7 = 1, then zero beats -> ch0 outputs for beats n=0..15 are 8n+1, then 0; ch1 is always 0.
REQ-035 DC saturate: all samples and all coefs 0x7FFF, defaults -> 0x7FFF per channel with FIR_SAT_EN; with it undefined, the low 16 bits of (121*0x7FFF*0x7FFF)>>>15.
REQ-036 Backpressure: m_tready=0 for 50 cycles in OUT -> m_tdata stable, s_tready=0 throughout, no beat lost; the next beat is accepted the cycle after the handshake.
REQ-037 Latency: a single accepted beat -> m_tvalid high exactly 122 cycles after the accepting edge.
REQ-038 Reset mid-MAC: rst at MAC cycle 40 -> no m_tvalid; a following beat of 1s with coef[0]=1, SHIFT=0 yields 1 (taps cleared).
REQ-039 Coef write during MAC: coef[0] write of 5 is ignored; the next result uses the old value; the same write in IDLE is applied.
